// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory write side and the PC reset logic.
package imem_pkg;

    localparam int unsigned IMEM_BASE_ADDR = 'h20;
    localparam int unsigned INSTR_WIDTH    = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLo,
        StHi,
        StWr,
        StDone
    } load_state_t;

endpackage

// File: rtl/byte_packer.sv
// Byte-stream handshake and little-endian assembly of one instruction word from two bytes.
module byte_packer
    import imem_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  load_state_t            state,
    input  load_state_t            next_state,
    input  logic                   s_valid,
    input  logic [7:0]             s_data,
    output logic                   s_ready,
    output logic                   byte_acc,
    output logic                   word_valid,
    output logic [INSTR_WIDTH-1:0] word
);

    logic       ready_q;
    logic [7:0] lo_q;

    // Ready is registered from the next state so it is valid in the same cycle as LO/HI.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
            lo_q    <= '0;
        end else begin
            ready_q <= (next_state == StLo) || (next_state == StHi);
            if (byte_acc && (state == StLo)) begin
                lo_q <= s_data;
            end
        end
    end

    assign s_ready    = ready_q;
    assign byte_acc   = s_valid & ready_q;
    assign word_valid = byte_acc && (state == StHi);
    assign word       = {s_data, lo_q};

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer; holds the core until the image is loaded.
// Define IMEM_LOADER_CHECKSUM_EN to receive and verify a trailing 16-bit sum word.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = INSTR_WIDTH,
    parameter int unsigned BASE_ADDR  = IMEM_BASE_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] word_count,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_hold,
    output logic                  csum_err
);

    localparam logic [ADDR_WIDTH-1:0] BaseA = ADDR_WIDTH'(BASE_ADDR);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    load_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d, idx_inc;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    mem_wr_q, mem_wr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    hold_q, hold_d;
    logic                    csum_err_q, csum_err_d;
    logic                    start_acc, last_word;
    logic                    byte_acc, word_valid;
    logic [INSTR_WIDTH-1:0]  word;
    logic                    in_chk, csum_bad;

    byte_packer u_byte_packer (
        .clk        (clk),
        .rst        (rst),
        .state      (state_q),
        .next_state (state_d),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .byte_acc   (byte_acc),
        .word_valid (word_valid),
        .word       (word)
    );

    assign start_acc = start && ((state_q == StIdle) || (state_q == StDone));
    assign idx_inc   = idx_q + ADDR_WIDTH'(1);
    assign last_word = (idx_inc == count_q);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [INSTR_WIDTH-1:0] sum_q;
    logic                   chk_q;

    // chk_q marks that the next LO/HI pair is the sum word rather than an image word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            chk_q <= 1'b0;
        end else if (start_acc) begin
            sum_q <= '0;
            chk_q <= 1'b0;
        end else begin
            if (word_valid && !chk_q) begin
                sum_q <= sum_q + word;
            end
            if ((state_q == StWr) && last_word) begin
                chk_q <= 1'b1;
            end
        end
    end

    assign in_chk   = chk_q;
    assign csum_bad = (word != sum_q);
`else
    assign in_chk   = 1'b0;
    assign csum_bad = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        data_d     = data_q;
        csum_err_d = csum_err_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_acc) begin
                    count_d    = word_count;
                    idx_d      = '0;
                    csum_err_d = 1'b0;
                    state_d    = (word_count == '0) ? StDone : StLo;
                end
            end
            StLo: begin
                if (byte_acc) begin
                    state_d = StHi;
                end
            end
            StHi: begin
                if (word_valid) begin
                    if (in_chk) begin
                        csum_err_d = csum_bad;
                        state_d    = StDone;
                    end else begin
                        addr_d  = BaseA + idx_q;
                        data_d  = DATA_WIDTH'(word);
                        state_d = StWr;
                    end
                end
            end
            StWr: begin
                idx_d = idx_inc;
                if (last_word) begin
                    state_d = ChkEn ? StLo : StDone;
                end else begin
                    state_d = StLo;
                end
            end
            default: state_d = StIdle;
        endcase

        mem_wr_d = (state_d == StWr);
        busy_d   = (state_d == StLo) || (state_d == StHi) || (state_d == StWr);
        done_d   = (state_d == StDone);
        // A failed checksum keeps the core parked until the next load or reset.
        hold_d   = busy_d || (done_d && csum_err_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            idx_q      <= '0;
            addr_q     <= BaseA;
            data_q     <= '0;
            mem_wr_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hold_q     <= 1'b0;
            csum_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            mem_wr_q   <= mem_wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hold_q     <= hold_d;
            csum_err_q <= csum_err_d;
        end
    end

    assign mem_wr   = mem_wr_q;
    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cpu_hold = hold_q;
    assign csum_err = csum_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: loads, stalls, ignored starts, reset, wrap, checksum.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, s_valid, s_ready, mem_wr, busy, done, cpu_hold, csum_err;
    logic [19:0] word_count, mem_addr;
    logic [7:0]  s_data;
    logic [15:0] mem_data;

    logic        start6, s_valid6, s_ready6, mem_wr6, busy6, done6, hold6, csum_err6;
    logic [5:0]  word_count6, mem_addr6;
    logic [7:0]  s_data6;
    logic [15:0] mem_data6;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .busy       (busy),
        .done       (done),
        .cpu_hold   (cpu_hold),
        .csum_err   (csum_err)
    );

    imem_loader #(.ADDR_WIDTH(6)) dut6 (
        .clk        (clk),
        .rst        (rst),
        .start      (start6),
        .word_count (word_count6),
        .s_valid    (s_valid6),
        .s_data     (s_data6),
        .s_ready    (s_ready6),
        .mem_wr     (mem_wr6),
        .mem_addr   (mem_addr6),
        .mem_data   (mem_data6),
        .busy       (busy6),
        .done       (done6),
        .cpu_hold   (hold6),
        .csum_err   (csum_err6)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [19:0] wr_addr[$];
    logic [15:0] wr_data[$];
    bit          ready_in_wr = 1'b0;
    int          n_wr6 = 0;
    logic [5:0]  first6 = '0;
    logic [5:0]  last6 = '0;

    always @(negedge clk) begin
        if (mem_wr) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_data);
            if (s_ready) ready_in_wr = 1'b1;
        end
        if (mem_wr6) begin
            if (n_wr6 == 0) first6 = mem_addr6;
            last6 = mem_addr6;
            n_wr6++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        if (gap) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) check("ready_timeout", {31'd0, s_ready}, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input bit gap);
        push_byte(w[7:0], gap);
        push_byte(w[15:8], gap);
    endtask

    task automatic close_load(input logic [15:0] sum);
        if (ChkEn) send_word(sum, 1'b0);
    endtask

    task automatic pulse_start(input logic [19:0] cnt);
        start      = 1'b1;
        word_count = cnt;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 30) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        ready_in_wr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; word_count = '0; s_valid = 1'b0; s_data = '0;
        start6 = 1'b0; word_count6 = '0; s_valid6 = 1'b0; s_data6 = '0;
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 'h20);
        check("rst_mem_data", mem_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_csum_err", csum_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back bytes
        clear_log();
        pulse_start(20'd2);
        check("t1_busy", busy, 1);
        check("t1_hold", cpu_hold, 1);
        check("t1_ready", s_ready, 1);
        send_word(16'h1234, 1'b0);
        send_word(16'h5678, 1'b0);
        close_load(16'h68AC);
        wait_done();
        check("t1_done", done, 1);
        check("t1_busy_end", busy, 0);
        check("t1_hold_end", cpu_hold, 0);
        check("t1_nwr", wr_addr.size(), 2);
        check("t1_addr0", wr_addr[0], 'h20);
        check("t1_data0", wr_data[0], 'h1234);
        check("t1_addr1", wr_addr[1], 'h21);
        check("t1_data1", wr_data[1], 'h5678);

        // Gappy source
        clear_log();
        pulse_start(20'd2);
        send_word(16'h1234, 1'b1);
        send_word(16'h5678, 1'b1);
        close_load(16'h68AC);
        wait_done();
        check("t2_done", done, 1);
        check("t2_nwr", wr_addr.size(), 2);
        check("t2_data0", wr_data[0], 'h1234);
        check("t2_data1", wr_data[1], 'h5678);
        check("t2_addr1", wr_addr[1], 'h21);
        check("t2_ready_in_wr", ready_in_wr, 0);

        // start while busy is ignored
        clear_log();
        pulse_start(20'd2);
        send_word(16'hBEEF, 1'b0);
        push_byte(8'h01, 1'b0);
        pulse_start(20'd5);
        check("t3_busy", busy, 1);
        push_byte(8'hCA, 1'b0);
        close_load(16'h88F0);
        wait_done();
        check("t3_done", done, 1);
        check("t3_nwr", wr_addr.size(), 2);
        check("t3_addr1", wr_addr[1], 'h21);
        check("t3_data1", wr_data[1], 'hCA01);

        // Reset during the write cycle
        clear_log();
        pulse_start(20'd2);
        send_word(16'h4321, 1'b0);
        check("t4_wr_before", mem_wr, 1);
        #1 rst = 1'b1;
        #1;
        check("t4_mem_wr", mem_wr, 0);
        check("t4_busy", busy, 0);
        check("t4_ready", s_ready, 0);
        check("t4_hold", cpu_hold, 0);
        check("t4_addr", mem_addr, 'h20);
        check("t4_data", mem_data, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Zero-length load
        clear_log();
        check("t5_done_before", done, 0);
        pulse_start(20'd0);
        check("t5_done", done, 1);
        check("t5_busy", busy, 0);
        check("t5_hold", cpu_hold, 0);
        repeat (3) @(negedge clk);
        check("t5_nwr", wr_addr.size(), 0);

        check("csum_err_idle", csum_err, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        clear_log();
        pulse_start(20'd2);
        send_word(16'h0001, 1'b0);
        send_word(16'hFFFF, 1'b0);
        send_word(16'h0000, 1'b0);
        wait_done();
        check("t6_csum_ok", csum_err, 0);
        check("t6_hold_ok", cpu_hold, 0);
        check("t6_nwr", wr_addr.size(), 2);
        check("t6_data1", wr_data[1], 'hFFFF);
        pulse_start(20'd2);
        send_word(16'h0001, 1'b0);
        send_word(16'hFFFF, 1'b0);
        send_word(16'h0001, 1'b0);
        wait_done();
        check("t6_done_bad", done, 1);
        check("t6_csum_bad", csum_err, 1);
        repeat (2) @(negedge clk);
        check("t6_hold_bad", cpu_hold, 1);
        check("t6_nwr_total", wr_addr.size(), 4);
`endif

        // Address wrap on the 6-bit instance
        s_valid6 = 1'b1;
        s_data6  = 8'hA5;
        start6      = 1'b1;
        word_count6 = 6'h21;
        @(negedge clk);
        start6 = 1'b0;
        for (int t = 0; t < 200 && !done6; t++) @(negedge clk);
        check("t7_done", done6, 1);
        check("t7_nwr", n_wr6, 33);
        check("t7_first", first6, 'h20);
        check("t7_last", last6, 'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the 16-bit instruction memory. Fetch is the read side of this memory; this block is the write side.
- Accepts a byte stream through a valid/ready handshake, packs byte pairs into 16-bit instruction words, and writes them to consecutive addresses starting at BASE_ADDR.
- Holds the core (cpu_hold) from start until loading completes, so fetch starts at BASE_ADDR only after the image is in place.

Parameters:
- ADDR_WIDTH, 20, instruction memory address bus width.
- DATA_WIDTH, 16, instruction word width; fixed at 2 bytes.
- BASE_ADDR, 'h20, first write address; equals the PC reset value.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse; begins a load. Ignored unless state is IDLE or DONE.
- word_count  input  ADDR_WIDTH  number of words to load; sampled on an accepted start.
- s_valid  input  1  byte stream valid.
- s_data  input  8  byte stream data.
- s_ready  output  1  loader can accept a byte.
- mem_wr  output  1  memory write enable; high for exactly one cycle per word.
- mem_addr  output  ADDR_WIDTH  write address.
- mem_data  output  DATA_WIDTH  write data.
- busy  output  1  a load is in progress.
- done  output  1  last load completed.
- cpu_hold  output  1  keep the core PC in reset.
- csum_err  output  1  checksum mismatch (see Optional Feature).

Behaviour:
- Reset (async):
  - State goes to IDLE.
  - s_ready, mem_wr, busy, done, cpu_hold, csum_err = 0.
  - mem_addr = BASE_ADDR, mem_data = 0, internal word index = 0.
- Reset mid-load: the in-flight write is dropped immediately (mem_wr falls asynchronously) and the partial byte is discarded.
- States: IDLE, LO, HI, WR, DONE.
- IDLE / DONE:
  - An accepted start latches word_count, clears index, clears done and csum_err, and sets busy and cpu_hold.
  - If word_count == 0, go to DONE with done = 1, busy = 0, cpu_hold = 0 in the next cycle. Otherwise go to LO.
- LO:
  - s_ready = 1.
  - On s_valid & s_ready, latch s_data into bits [7:0] and go to HI.
- HI:
  - s_ready = 1.
  - On handshake, latch s_data into bits [15:8] and go to WR.
  - Byte order is little-endian.
- WR:
  - s_ready = 0; mem_wr = 1 for one cycle.
  - mem_addr = BASE_ADDR + index, truncated modulo 2^ADDR_WIDTH (wraps to 0).
  - mem_data = the assembled word.
  - Then increment index. If index+1 == word_count, go to DONE; otherwise go to LO.
- All outputs are registered.
  - mem_wr rises the cycle after the high byte is accepted.
  - Minimum of 3 cycles per word.
- DONE:
  - done = 1 and stays high until the next accepted start or reset.
  - busy = 0, cpu_hold = 0.
- s_valid while s_ready = 0: the byte is not consumed, and the source must hold it.
- start while busy: ignored.
- start in the same cycle as the completing write: ignored, because the state is WR.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - Keep a 16-bit wrapping sum of all written words.
  - After the last word, receive one extra little-endian word (states LO/HI); it is not written to memory (no mem_wr).
  - If the extra word differs from the sum, set csum_err = 1 together with done.
  - cpu_hold stays 1 while csum_err = 1, until the next start or reset.
- Disabled:
  - No extra word.
  - csum_err is tied to 0.

Decomposition:
- Shared package `imem_pkg`:
  - Enum for the state encoding (IDLE, LO, HI, WR, DONE).
  - BASE_ADDR default constant ('h20), shared with the PC logic.
  - Instruction width constant (16).
- Optional sub-module `byte_packer`: LO/HI byte assembly with the handshake, outputs a word_valid pulse.
- The top level keeps the index counter, the address, the write strobe and the checksum.

Test Plan:
- Reset → all outputs 0, mem_addr = 'h20. Assert rst during WR → mem_wr falls the same cycle and state is IDLE.
- start with word_count = 2, bytes 34,12,78,56 → writes 'h1234 @'h20 and 'h5678 @'h21, then done = 1, cpu_hold = 0.
- Same load with s_valid toggling every other cycle → identical writes, no byte lost or duplicated, s_ready low in WR.
- start with word_count = 0 → done the next cycle, no mem_wr. A start pulse while busy → ignored, count unchanged.
- ADDR_WIDTH = 6, word_count = 'h21 → the last write wraps to address 'h00.
- With IMEM_LOADER_CHECKSUM_EN, words 'h0001, 'hFFFF:
  - Checksum word 'h0000 → csum_err = 0.
  - Checksum word 'h0001 → csum_err = 1 and cpu_hold stays 1.
